// File: rtl/hilo_mul_ctrl.sv
// HI/LO register pair and sequencer for an external 32x32 unsigned multiplier.
// Define HILO_MUL_CTRL_SIGNED_EN to honour is_signed (MULT); otherwise every request is MULTU.
module hilo_mul_ctrl #(
   parameter int unsigned LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_result,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      WB   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        done_q, done_d;
   logic        accept;
   logic [31:0] op_a_mag, op_b_mag;
   logic [63:0] product;

   assign accept = start && (state_q != CALC);

`ifdef HILO_MUL_CTRL_SIGNED_EN
   logic neg_q;

   // Two's-complement magnitude; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
   assign op_a_mag = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
   assign op_b_mag = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
   assign product  = neg_q ? (~mul_result + 64'd1) : mul_result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q <= 1'b0;
      end else if (accept) begin
         neg_q <= is_signed && (op_a[31] ^ op_b[31]);
      end
   end
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign op_a_mag         = op_a;
   assign op_b_mag         = op_b;
   assign product          = mul_result;
`endif

   // NOTE: every variable gets its hold value before the case so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         CALC: begin
            if (cnt_q == 4'd0) begin
               hi_d    = product[63:32];
               lo_d    = product[31:0];
               done_d  = 1'b1;
               state_d = WB;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            // IDLE and WB behave alike; a start wins over mthi/mtlo in the same cycle.
            if (accept) begin
               mul_a_d = op_a_mag;
               mul_b_d = op_b_mag;
               cnt_d   = CNT_INIT;
               state_d = CALC;
            end else begin
               if (mthi) hi_d = wdata;
               if (mtlo) lo_d = wdata;
               state_d = IDLE;
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         mul_a_q <= 32'd0;
         mul_b_q <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign mul_a = mul_a_q;
   assign mul_b = mul_b_q;
   assign busy  = (state_q == CALC);
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
